wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port of the write-back stage among NUM_REQ producers (ALU, load unit, multiply/divide).
- Producers present results on independent valid/ready channels.
- The arbiter grants one producer per cycle, round-robin, and drives a registered one-cycle write pulse to the register file.
- It also keeps a 32-entry busy scoreboard: issue sets a register's bit and write-back clears it. The hazard logic in decode reads this scoreboard.

Parameters:
- NUM_REQ, 3, number of producers; legal range 2..8.
- XLEN, 32, data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  producer i has a result.
- req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- req_rd  input  NUM_REQ*5  destination register per producer; producer i occupies bits [5i+4:5i].
- req_data  input  NUM_REQ*XLEN  result per producer; producer i occupies bits [XLEN*i+XLEN-1:XLEN*i].
- wb_stall  input  1  hazard unit freezes the write port.
- issue_valid  input  1  an instruction with a destination register issues this cycle.
- issue_rd  input  5  destination register of the issuing instruction.
- regb_write_enable  output  1  register-file write strobe.
- destination_register  output  5  register-file write address.
- data_in  output  XLEN  register-file write data.
- busy_mask  output  32  bit r set means register r has a pending write.

Behaviour:
- Reset (rst low, asynchronous):
  - regb_write_enable = 0, destination_register = 0, data_in = 0, busy_mask = 0.
  - Round-robin pointer = NUM_REQ-1, so producer 0 has first priority.
  - Any in-flight write is dropped.
- Reset mid-operation: a write registered but not yet presented is lost, and no pulse follows reset release. req_ready is 0 while rst is low.
- Grant logic (combinational):
  - When wb_stall = 0, req_ready is one-hot on the first valid producer found searching upward from pointer+1, with modulo-NUM_REQ wrap.
  - req_ready = 0 when no producer is valid, when wb_stall = 1, or when rst is low.
  - req_ready never asserts for a producer whose req_valid is low.
- Pointer:
  - On an accepted transfer from producer g, the pointer becomes g.
  - Otherwise the pointer holds; stall cycles and idle cycles do not advance it.
- Latency:
  - A transfer accepted at edge t drives regb_write_enable, destination_register and data_in during cycle t+1.
  - The register file writes at edge t+1.
  - regb_write_enable is high for exactly one cycle per transfer.
  - Throughput is one write per cycle.
- x0 handling:
  - A transfer with rd = 0 is accepted and consumes the grant and the pointer update.
  - It produces regb_write_enable = 0.
  - destination_register and data_in still update and are don't-care.
- Idle or stall cycle: regb_write_enable = 0 next cycle; destination_register and data_in hold their previous values.
- Scoreboard:
  - issue_valid with issue_rd != 0 sets busy_mask[issue_rd] at the edge.
  - issue_rd = 0 is ignored; busy_mask[0] is always 0.
  - The edge that completes the write (regb_write_enable high and destination_register = r) clears busy_mask[r].
  - If a set and a clear of the same r fall on the same edge, the set wins (a newer producer is pending).
  - If sets and clears target different registers on the same edge, both apply.
  - Setting a bit that is already set leaves it set; the scoreboard does no counting.
- No internal buffering: a producer holds req_valid, req_rd and req_data stable until granted. Dropping req_valid before the grant is legal (the request is withdrawn).

Test Plan:
- Reset then single request: rst low for 2 cycles, then release; req_valid = 3'b001, rd = 5, data = 32'hDEADBEEF for 1 cycle -> req_ready = 3'b001 that cycle; next cycle regb_write_enable = 1, destination_register = 5, data_in = DEADBEEF; the cycle after, regb_write_enable = 0.
- Round-robin fairness: all three producers valid continuously for 6 cycles with rd = 1, 2, 3 -> grant order 0,1,2,0,1,2; write addresses 1,2,3,1,2,3 one cycle later; no gaps.
- Stall: all producers valid, wb_stall = 1 for 3 cycles mid-sequence after granting producer 1 -> req_ready = 0 and regb_write_enable = 0 during the stall; the first grant after release goes to producer 2.
- x0 suppression: producer 2 sends rd = 0, data = 32'h12345678 -> req_ready[2] = 1; next cycle regb_write_enable = 0; the pointer advances so the next simultaneous request from producers 0 and 2 goes to producer 0.
- Scoreboard:
  - issue_valid with issue_rd = 7 -> busy_mask[7] = 1 next cycle.
  - Producer 0 writes rd = 7 -> bit clears after the write edge.
  - issue of rd = 7 on the same edge as the write -> busy_mask[7] stays 1.
  - issue_rd = 0 -> busy_mask stays 0.
- Async reset mid-flight: transfer accepted, then rst pulsed low mid-cycle before the next edge -> all outputs 0 immediately; no write pulse after release; busy_mask = 0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: round-robin grant of the single register-file
// write port among NUM_REQ producers, plus a 32-entry pending-write scoreboard.
module wb_port_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*5-1:0]    req_rd,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  input  logic                    wb_stall,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  output logic                    regb_write_enable,
  output logic [4:0]              destination_register,
  output logic [XLEN-1:0]         data_in,
  output logic [31:0]             busy_mask
);

  localparam int unsigned RW = 5;
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]   ptr_q;
  logic [NUM_REQ-1:0] grant_c;
  logic [PW-1:0]   gidx_c;
  logic            xfer_c;
  logic [PW-1:0]   idx_c;
  logic [RW-1:0]   sel_rd_c;
  logic [XLEN-1:0] sel_data_c;
  logic [31:0]     clr_c;
  logic [31:0]     set_c;
  logic [31:0]     busy_d_c;

  // Round-robin search upward from ptr+1; gated off by stall and reset.
  always_comb begin
    grant_c = '0;
    gidx_c  = ptr_q;
    xfer_c  = 1'b0;
    idx_c   = '0;
    if (rst && !wb_stall) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        idx_c = PW'((32'(ptr_q) + k) % NUM_REQ);
        if (!xfer_c && req_valid[idx_c]) begin
          grant_c[idx_c] = 1'b1;
          gidx_c         = idx_c;
          xfer_c         = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant_c;

  // Payload mux driven by the one-hot grant.
  always_comb begin
    sel_rd_c   = '0;
    sel_data_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        sel_rd_c   = req_rd[i*RW +: RW];
        sel_data_c = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Pointer and registered write port; rd=0 transfers update address/data but never strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q                <= PW'(NUM_REQ - 1);
      regb_write_enable    <= 1'b0;
      destination_register <= '0;
      data_in              <= '0;
    end else begin
      regb_write_enable <= xfer_c && (sel_rd_c != '0);
      if (xfer_c) begin
        ptr_q                <= gidx_c;
        destination_register <= sel_rd_c;
        data_in              <= sel_data_c;
      end
    end
  end

  // Scoreboard next state: completing write clears, issue sets, set wins on collision.
  always_comb begin
    clr_c = '0;
    set_c = '0;
    if (regb_write_enable) begin
      clr_c[destination_register] = 1'b1;
    end
    if (issue_valid && (issue_rd != '0)) begin
      set_c[issue_rd] = 1'b1;
    end
    busy_d_c = ((busy_mask & ~clr_c) | set_c) & ~32'd1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_mask <= '0;
    end else begin
      busy_mask <= busy_d_c;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural model of the arbitration rules.
module tb_wb_port_arbiter;

  localparam int N    = 3;
  localparam int XLEN = 32;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [4:0]        rdv   [N];
  logic [XLEN-1:0]   datav [N];
  logic [N*5-1:0]    req_rd;
  logic [N*XLEN-1:0] req_data;
  logic              wb_stall;
  logic              issue_valid;
  logic [4:0]        issue_rd;
  logic              regb_write_enable;
  logic [4:0]        destination_register;
  logic [XLEN-1:0]   data_in;
  logic [31:0]       busy_mask;

  int checks;
  int errors;

  // Reference model state
  int              m_ptr;
  bit              m_we;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;
  bit              m_busy [32];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pack
      assign req_rd[gi*5 +: 5]         = rdv[gi];
      assign req_data[gi*XLEN +: XLEN] = datav[gi];
    end
  endgenerate

  wb_port_arbiter #(.NUM_REQ(N), .XLEN(XLEN)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_rd               (req_rd),
    .req_data             (req_data),
    .wb_stall             (wb_stall),
    .issue_valid          (issue_valid),
    .issue_rd             (issue_rd),
    .regb_write_enable    (regb_write_enable),
    .destination_register (destination_register),
    .data_in              (data_in),
    .busy_mask            (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner = valid producer with the smallest circular distance past the pointer.
  function automatic int model_grant();
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N;
    if (!rst || wb_stall) return -1;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i]) begin
        d = (i - m_ptr - 1 + 2*N) % N;
        if (d < bestd) begin
          best  = i;
          bestd = d;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    m_ptr  = N - 1;
    m_we   = 1'b0;
    m_rd   = '0;
    m_data = '0;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endtask

  // Advance one clock edge and update the model with what that edge does.
  task automatic tick();
    int g;
    g = model_grant();
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (m_we && m_rd != 0) m_busy[m_rd] = 1'b0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (g >= 0) begin
        m_we   = (rdv[g] != 0);
        m_rd   = rdv[g];
        m_data = datav[g];
        m_ptr  = g;
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    req_valid   = '0;
    wb_stall    = 1'b0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    for (int i = 0; i < N; i++) begin
      rdv[i]   = '0;
      datav[i] = '0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    req_valid = 3'b111;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
    checks++; if (regb_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", regb_write_enable); end
    checks++; if (destination_register !== 5'd0) begin errors++; $display("FAIL reset_dest: got %0d expected 0", destination_register); end
    checks++; if (data_in !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_in); end
    checks++; if (busy_mask !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_mask); end
    @(posedge clk);
    model_reset();
    #1;
    req_valid = '0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    req_valid = 3'b001;
    rdv[0]    = 5'd5;
    datav[0]  = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_grant: got %b expected 001", req_ready); end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++; if (regb_write_enable !== 1'b1) begin errors++; $display("FAIL single_we: got %b expected 1", regb_write_enable); end
    checks++; if (destination_register !== 5'd5) begin errors++; $display("FAIL single_dest: got %0d expected 5", destination_register); end
    checks++; if (data_in !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h expected deadbeef", data_in); end
    tick();
    @(negedge clk);
    checks++; if (regb_write_enable !== 1'b0) begin errors++; $display("FAIL single_we_drop: got %b expected 0", regb_write_enable); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e;
    do_reset();
    req_valid = 3'b111;
    for (int i = 0; i < N; i++) begin
      rdv[i]   = 5'(i + 1);
      datav[i] = 32'hA000_0000 + 32'(i);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      e = '0;
      e[k % 3] = 1'b1;
      checks++; if (req_ready !== e) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, e); end
      if (k > 0) begin
        checks++;
        if (regb_write_enable !== 1'b1 || destination_register !== 5'((k - 1) % 3 + 1)) begin
          errors++;
          $display("FAIL rr_write%0d: got we=%b rd=%0d expected we=1 rd=%0d", k, regb_write_enable, destination_register, (k - 1) % 3 + 1);
        end
      end
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    checks++; if (regb_write_enable !== 1'b1 || destination_register !== 5'd3 || data_in !== 32'hA000_0002) begin
      errors++; $display("FAIL rr_last: got we=%b rd=%0d data=%h expected we=1 rd=3 data=a0000002", regb_write_enable, destination_register, data_in);
    end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    req_valid = 3'b111;
    for (int i = 0; i < N; i++) rdv[i] = 5'(i + 1);
    @(negedge clk);
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL stall_g0: got %b expected 001", req_ready); end
    tick();
    @(negedge clk);
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL stall_g1: got %b expected 010", req_ready); end
    tick();
    wb_stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL stall_ready%0d: got %b expected 000", s, req_ready); end
      checks++; if (regb_write_enable !== (s == 0)) begin errors++; $display("FAIL stall_we%0d: got %b expected %b", s, regb_write_enable, s == 0); end
      tick();
    end
    wb_stall = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL stall_resume: got %b expected 100", req_ready); end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++; if (regb_write_enable !== 1'b1 || destination_register !== 5'd3) begin
      errors++; $display("FAIL stall_write: got we=%b rd=%0d expected we=1 rd=3", regb_write_enable, destination_register);
    end
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    req_valid = 3'b100;
    rdv[2]    = 5'd0;
    datav[2]  = 32'h12345678;
    @(negedge clk);
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL x0_grant: got %b expected 100", req_ready); end
    tick();
    req_valid = 3'b101;
    rdv[0]    = 5'd4;
    rdv[2]    = 5'd6;
    @(negedge clk);
    checks++; if (regb_write_enable !== 1'b0) begin errors++; $display("FAIL x0_we: got %b expected 0", regb_write_enable); end
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL x0_next_grant: got %b expected 001", req_ready); end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++; if (regb_write_enable !== 1'b1 || destination_register !== 5'd4) begin
      errors++; $display("FAIL x0_follow: got we=%b rd=%0d expected we=1 rd=4", regb_write_enable, destination_register);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy_mask !== 32'h80) begin errors++; $display("FAIL sb_set: got %h expected 00000080", busy_mask); end
    req_valid = 3'b001; rdv[0] = 5'd7; datav[0] = 32'h77;
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++; if (regb_write_enable !== 1'b1 || busy_mask !== 32'h80) begin
      errors++; $display("FAIL sb_pending: got we=%b busy=%h expected we=1 busy=00000080", regb_write_enable, busy_mask);
    end
    tick();
    @(negedge clk);
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL sb_clear: got %h expected 0", busy_mask); end
    // Set and clear of r7 on the same edge
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy_mask !== 32'h80) begin errors++; $display("FAIL sb_set_wins: got %h expected 00000080", busy_mask); end
    // Clear r7 while setting r9 on the same edge
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy_mask !== 32'h200) begin errors++; $display("FAIL sb_mixed_x0: got %h expected 00000200", busy_mask); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = 3'b001; rdv[0] = 5'd3; datav[0] = 32'hCAFE0003;
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (regb_write_enable !== 1'b0 || destination_register !== 5'd0 || data_in !== 32'd0) begin
      errors++; $display("FAIL async_outputs: got we=%b rd=%0d data=%h expected all 0", regb_write_enable, destination_register, data_in);
    end
    checks++; if (busy_mask !== 32'd0) begin errors++; $display("FAIL async_busy: got %h expected 0", busy_mask); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL async_ready: got %b expected 000", req_ready); end
    model_reset();
    @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (regb_write_enable !== 1'b0 || busy_mask !== 32'd0) begin
        errors++; $display("FAIL async_release%0d: got we=%b busy=%h expected we=0 busy=0", c, regb_write_enable, busy_mask);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int g;
    logic [N-1:0] e;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid   = N'($urandom);
      wb_stall    = ($urandom_range(0, 3) == 0);
      issue_valid = $urandom_range(0, 1) == 1;
      issue_rd    = 5'($urandom);
      for (int i = 0; i < N; i++) begin
        rdv[i]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        datav[i] = $urandom;
      end
      @(negedge clk);
      g = model_grant();
      e = '0;
      if (g >= 0) e[g] = 1'b1;
      checks++; if (req_ready !== e) begin errors++; $display("FAIL rand_grant c%0d: got %b expected %b", c, req_ready, e); end
      checks++; if (regb_write_enable !== m_we) begin errors++; $display("FAIL rand_we c%0d: got %b expected %b", c, regb_write_enable, m_we); end
      checks++; if (destination_register !== m_rd || data_in !== m_data) begin
        errors++; $display("FAIL rand_port c%0d: got rd=%0d data=%h expected rd=%0d data=%h", c, destination_register, data_in, m_rd, m_data);
      end
      checks++; if (busy_mask !== model_busy()) begin errors++; $display("FAIL rand_busy c%0d: got %h expected %h", c, busy_mask, model_busy()); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_x0();
    test_scoreboard();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
